// File: rtl/mixpix_phase_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mixpix_phase_seq
//  Description : Frame phase sequencer for a mixed-signal pixel. Steps the
//                analog switches through reset / integrate / sample phases
//                with one-cycle break-before-make gaps. It then runs a
//                ramp-style conversion counter that is stopped by a
//                synchronised comparator, and shifts the result out MSB first.
//  Revision    : 1.0  - initial release
// ============================================================================
module mixpix_phase_seq #(
    parameter int RST_CYC = 4,
    parameter int CNT_W   = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [15:0]      t_int_i,
    input  logic [7:0]       t_sh_i,
    input  logic             cmp_i,
    output logic             sh_rst_o,
    output logic             sw1_o,
    output logic             sw2_o,
    output logic             sh_o,
    output logic             sh_cmp_o,
    output logic             counter_rst_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             data_o,
    output logic             data_vld_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_RST     = 4'd1,
        S_G1      = 4'd2,
        S_INTEG   = 4'd3,
        S_G2      = 4'd4,
        S_SAMPLE  = 4'd5,
        S_G3      = 4'd6,
        S_CONVERT = 4'd7,
        S_SHIFT   = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    state_t             state;
    state_t             nxt;
    logic [15:0]        tmr;
    logic [15:0]        load_val;
    logic [15:0]        t_int_q;
    logic [7:0]         t_sh_q;
    logic               cmp_meta;
    logic               cmp_s;
    logic [CNT_W-1:0]   conv_cnt;
    logic [CNT_W-1:0]   shreg;
    logic               cnt_max;
    logic               accept;
    logic               conv_exit;
    logic               conv_entry;

    assign cnt_max    = (conv_cnt == {CNT_W{1'b1}});
    assign accept     = (state == S_IDLE) && start_i;
    assign conv_exit  = (state == S_CONVERT) && (nxt == S_SHIFT);
    assign conv_entry = (state != S_CONVERT) && (nxt == S_CONVERT);

    // Next-state decode and phase-timer reload value for the state being entered.
    always_comb begin
        nxt      = state;
        load_val = 16'd0;
        case (state)
            S_IDLE:    if (start_i)           nxt = S_RST;
            S_RST:     if (tmr == 16'd0)      nxt = S_G1;
            S_G1:                             nxt = S_INTEG;
            S_INTEG:   if (tmr == 16'd0)      nxt = S_G2;
            S_G2:                             nxt = S_SAMPLE;
            S_SAMPLE:  if (tmr == 16'd0)      nxt = S_G3;
            S_G3:                             nxt = S_CONVERT;
            S_CONVERT: if (cmp_s || cnt_max)  nxt = S_SHIFT;
            S_SHIFT:   if (tmr == 16'd0)      nxt = S_DONE;
            S_DONE:                           nxt = S_IDLE;
            default:                          nxt = S_IDLE;
        endcase
        case (nxt)
            S_RST:    load_val = 16'(RST_CYC - 1);
            S_INTEG:  load_val = t_int_q - 16'd1;
            S_SAMPLE: load_val = {8'd0, t_sh_q} - 16'd1;
            S_SHIFT:  load_val = 16'(CNT_W - 1);
            default:  load_val = 16'd0;
        endcase
    end

    // Two-flop synchroniser for the asynchronous comparator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmp_meta <= 1'b0;
            cmp_s    <= 1'b0;
        end else begin
            cmp_meta <= cmp_i;
            cmp_s    <= cmp_meta;
        end
    end

    // State register, phase timer and registered phase controls decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= S_IDLE;
            tmr           <= 16'd0;
            sh_rst_o      <= 1'b0;
            sw1_o         <= 1'b0;
            sw2_o         <= 1'b0;
            sh_o          <= 1'b0;
            sh_cmp_o      <= 1'b0;
            counter_rst_o <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            data_vld_o    <= 1'b0;
        end else begin
            state <= nxt;
            if (nxt != state) begin
                tmr <= load_val;
            end else if (tmr != 16'd0) begin
                tmr <= tmr - 16'd1;
            end
            sh_rst_o      <= (nxt == S_RST);
            sw1_o         <= (nxt == S_INTEG);
            sw2_o         <= (nxt == S_SAMPLE);
            sh_o          <= (nxt == S_SAMPLE);
            sh_cmp_o      <= (nxt == S_CONVERT);
            counter_rst_o <= conv_entry;
            busy_o        <= (nxt != S_IDLE);
            done_o        <= (nxt == S_DONE);
            data_vld_o    <= (nxt == S_SHIFT);
        end
    end

    // Frame parameters are captured on start; a zero length is stretched to one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            t_int_q <= 16'd1;
            t_sh_q  <= 8'd1;
        end else if (accept) begin
            t_int_q <= (t_int_i == 16'd0) ? 16'd1 : t_int_i;
            t_sh_q  <= (t_sh_i == 8'd0) ? 8'd1 : t_sh_i;
        end
    end

    // Conversion counter: cleared on entry, counts while the comparator is low, saturates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conv_cnt <= '0;
            count_o  <= '0;
            ovf_o    <= 1'b0;
        end else begin
            if (conv_entry) begin
                conv_cnt <= '0;
            end else if ((state == S_CONVERT) && !cmp_s && !cnt_max) begin
                conv_cnt <= conv_cnt + 1'b1;
            end
            if (conv_exit) begin
                count_o <= conv_cnt;
            end
            if (accept) begin
                ovf_o <= 1'b0;
            end else if ((state == S_CONVERT) && !cmp_s && cnt_max) begin
                ovf_o <= 1'b1;
            end
        end
    end

    // Serialiser: first bit is taken straight from the counter on the conversion exit edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg  <= '0;
            data_o <= 1'b0;
        end else if (conv_exit) begin
            data_o <= conv_cnt[CNT_W-1];
            shreg  <= {conv_cnt[CNT_W-2:0], 1'b0};
        end else if (nxt == S_SHIFT) begin
            data_o <= shreg[CNT_W-1];
            shreg  <= {shreg[CNT_W-2:0], 1'b0};
        end else begin
            data_o <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mixpix_phase_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mixpix_phase_seq
//  Description : Self-checking bench for mixpix_phase_seq, with a 12-bit and a
//                4-bit counter instance. Frame results are queued at start and
//                checked when done_o is seen.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_mixpix_phase_seq;

    localparam int RST_CYC = 4;
    localparam int W_A     = 12;
    localparam int W_B     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] t_int;
    logic [7:0]  t_sh;
    logic        start_a, start_b, cmp_a, cmp_b;

    // {sh_rst, sw1, sw2, sh, sh_cmp, counter_rst, busy, done, data, data_vld}
    wire [9:0]     ctl_a, ctl_b;
    wire [W_A-1:0] cnt_a;
    wire [W_B-1:0] cnt_b;
    wire           ovf_a, ovf_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int t_int;
        int t_sh;
        int cmp_at;     // -1: held low, 0: held high, k: rises in CONVERT cycle k
        bit sel;        // 0: 12-bit instance, 1: 4-bit instance
        bit poke;       // pulse start during INTEG
        int exp_count;
        bit exp_ovf;
    } vec_t;

    typedef struct {
        int count;
        bit ovf;
    } exp_t;

    vec_t tbl[7];
    exp_t sb[$];

    always #5 clk = ~clk;

    mixpix_phase_seq #(.RST_CYC(RST_CYC), .CNT_W(W_A)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a), .t_int_i(t_int), .t_sh_i(t_sh),
        .cmp_i(cmp_a),
        .sh_rst_o(ctl_a[9]), .sw1_o(ctl_a[8]), .sw2_o(ctl_a[7]), .sh_o(ctl_a[6]),
        .sh_cmp_o(ctl_a[5]), .counter_rst_o(ctl_a[4]), .busy_o(ctl_a[3]),
        .done_o(ctl_a[2]), .data_o(ctl_a[1]), .data_vld_o(ctl_a[0]),
        .count_o(cnt_a), .ovf_o(ovf_a)
    );

    mixpix_phase_seq #(.RST_CYC(RST_CYC), .CNT_W(W_B)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b), .t_int_i(t_int), .t_sh_i(t_sh),
        .cmp_i(cmp_b),
        .sh_rst_o(ctl_b[9]), .sw1_o(ctl_b[8]), .sw2_o(ctl_b[7]), .sh_o(ctl_b[6]),
        .sh_cmp_o(ctl_b[5]), .counter_rst_o(ctl_b[4]), .busy_o(ctl_b[3]),
        .done_o(ctl_b[2]), .data_o(ctl_b[1]), .data_vld_o(ctl_b[0]),
        .count_o(cnt_b), .ovf_o(ovf_b)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_start(input bit sel, input logic val);
        if (sel) start_b = val;
        else     start_a = val;
    endtask

    task automatic run_frame(input int idx, input vec_t v);
        logic [9:0] c;
        int ti, ts, w, n_conv, exp_len;
        int n_rst = 0, n_sw1 = 0, n_sw2 = 0, n_sh = 0, n_cv = 0, n_crst = 0;
        int n_done = 0, n_len = 0, n_gap = 0, n_vld = 0, n_stray = 0, n_ovl = 0;
        int conv_k = 0, ser = 0, exp_ser = -1;
        bit poked = 1'b0, poke_hold = 1'b0, timeout = 1'b1;
        exp_t e;

        ti = (v.t_int == 0) ? 1 : v.t_int;
        ts = (v.t_sh == 0) ? 1 : v.t_sh;
        w  = v.sel ? W_B : W_A;
        if (v.cmp_at < 0)       n_conv = 1 << w;
        else if (v.cmp_at == 0) n_conv = 1;
        else                    n_conv = v.cmp_at + 2;
        exp_len = RST_CYC + ti + ts + 3 + n_conv + w + 1;

        t_int = 16'(v.t_int);
        t_sh  = 8'(v.t_sh);
        if (v.sel) cmp_b = (v.cmp_at == 0);
        else       cmp_a = (v.cmp_at == 0);

        @(negedge clk);
        drive_start(v.sel, 1'b1);
        sb.push_back('{v.exp_count, v.exp_ovf});
        @(negedge clk);
        drive_start(v.sel, 1'b0);

        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (poke_hold) begin
                drive_start(v.sel, 1'b0);
                poke_hold = 1'b0;
            end
            c = v.sel ? ctl_b : ctl_a;
            if (!c[3]) begin
                timeout = 1'b0;
                break;
            end
            n_len++;
            n_rst  += int'(c[9]);
            n_sw1  += int'(c[8]);
            n_sw2  += int'(c[7]);
            n_sh   += int'(c[6]);
            n_cv   += int'(c[5]);
            n_crst += int'(c[4]);
            n_done += int'(c[2]);
            if (c[9:5] == 5'd0 && !c[0] && !c[2]) n_gap++;
            if (c[1] && !c[0]) n_stray++;
            if ($countones({c[9], c[8], c[6], c[5]}) > 1) n_ovl++;
            if (c[0]) begin
                n_vld++;
                ser = (ser << 1) | int'(c[1]);
            end
            if (c[5]) begin
                conv_k++;
                if (conv_k == v.cmp_at) begin
                    if (v.sel) cmp_b = 1'b1;
                    else       cmp_a = 1'b1;
                end
            end
            if (v.poke && c[8] && !poked) begin
                drive_start(v.sel, 1'b1);
                poked     = 1'b1;
                poke_hold = 1'b1;
            end
            if (c[2]) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL e%0d_sb_underflow: got empty queue expected one entry", idx);
                end else begin
                    e = sb.pop_front();
                    exp_ser = e.count;
                    check($sformatf("e%0d_count", idx), v.sel ? int'(cnt_b) : int'(cnt_a), e.count);
                    check($sformatf("e%0d_ovf", idx), v.sel ? int'(ovf_b) : int'(ovf_a), int'(e.ovf));
                end
            end
            @(negedge clk);
        end
        drive_start(v.sel, 1'b0);

        check($sformatf("e%0d_timeout", idx), int'(timeout), 0);
        check($sformatf("e%0d_sh_rst_cyc", idx), n_rst, RST_CYC);
        check($sformatf("e%0d_sw1_cyc", idx), n_sw1, ti);
        check($sformatf("e%0d_sw2_cyc", idx), n_sw2, ts);
        check($sformatf("e%0d_sh_cyc", idx), n_sh, ts);
        check($sformatf("e%0d_conv_cyc", idx), n_cv, n_conv);
        check($sformatf("e%0d_counter_rst", idx), n_crst, 1);
        check($sformatf("e%0d_done_pulses", idx), n_done, 1);
        check($sformatf("e%0d_frame_len", idx), n_len, exp_len);
        check($sformatf("e%0d_gap_cyc", idx), n_gap, 3);
        check($sformatf("e%0d_vld_cyc", idx), n_vld, w);
        check($sformatf("e%0d_serial", idx), ser, exp_ser);
        check($sformatf("e%0d_data_outside", idx), n_stray, 0);
        check($sformatf("e%0d_overlap", idx), n_ovl, 0);
    endtask

    initial begin
        bit seen;

        tbl[0] = '{10, 3, 20, 1'b0, 1'b0, 21,   1'b0};
        tbl[1] = '{5,  2, 0,  1'b0, 1'b0, 0,    1'b0};
        tbl[2] = '{0,  0, 5,  1'b0, 1'b0, 6,    1'b0};
        tbl[3] = '{10, 3, 20, 1'b0, 1'b1, 21,   1'b0};
        tbl[4] = '{2,  2, 9,  1'b1, 1'b0, 10,   1'b0};
        tbl[5] = '{7,  4, 2729, 1'b0, 1'b0, 2730, 1'b0};
        tbl[6] = '{3,  1, -1, 1'b1, 1'b0, 15,   1'b1};

        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        cmp_a   = 1'b0;
        cmp_b   = 1'b0;
        t_int   = 16'd0;
        t_sh    = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_ctl_a", int'(ctl_a), 0);
        check("rst_ctl_b", int'(ctl_b), 0);
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_ovf_a", int'(ovf_a), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_frame(i, tbl[i]);
        end

        // Asynchronous reset in the middle of SAMPLE.
        t_int = 16'd10;
        t_sh  = 8'd3;
        cmp_a = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ctl_a[6]) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mid_reach_sample", int'(seen), 1);
        check("mid_pre_cnt_a", int'(cnt_a), 2730);
        check("mid_pre_ovf_b", int'(ovf_b), 1);
        rst_n = 1'b0;
        #1;
        check("mid_arst_ctl_a", int'(ctl_a), 0);
        check("mid_arst_busy_a", int'(ctl_a[3]), 0);
        check("mid_arst_cnt_a", int'(cnt_a), 0);
        check("mid_arst_ovf_b", int'(ovf_b), 0);
        @(negedge clk);
        check("mid_hold_ctl_a", int'(ctl_a), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", int'(ctl_a[3]), 0);
        run_frame(7, tbl[0]);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
